// File: rtl/imem_loader_if.sv
// imem_loader_if: control, byte-stream and memory-write signals of the instruction memory loader
//   master: start, base_addr, word_count, rx_valid, rx_data -> ; <- rx_ready, we, waddr, wdata, busy, cpu_hold, done
//   slave : mirror image, used by imem_loader
interface imem_loader_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] word_count;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  cpu_hold;
    logic                  done;
    modport master (
        output start, base_addr, word_count, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, busy, cpu_hold, done
    );
    modport slave (
        input  start, base_addr, word_count, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, busy, cpu_hold, done
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream MSB-first into instruction words and writes them to consecutive addresses
//   clk, reset (async, active-high)
//   bus.slave: start/base_addr/word_count begin a load; rx_valid/rx_data/rx_ready carry bytes;
//              we/waddr/wdata write instruction memory; busy/cpu_hold/done report progress
module imem_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
) (
    input logic        clk,
    input logic        reset,
    imem_loader_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IW = $clog2(NBYTES) + 1;
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;
    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr, remaining, waddr_q;
    logic [IW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] shreg, wdata_q, shreg_nx;
    logic                  accept, last_byte;
    assign accept    = (state == COLLECT) && bus.rx_valid;
    assign last_byte = byte_idx == IW'(NBYTES - 1);
    assign shreg_nx  = {shreg[DATA_WIDTH-9:0], bus.rx_data};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? ((bus.word_count == '0) ? FINISH : COLLECT) : IDLE;
            COLLECT: state_nx = (accept && last_byte) ? WRITE : COLLECT;
            WRITE:   state_nx = (remaining == ADDR_WIDTH'(1)) ? FINISH : COLLECT;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.rx_ready = state == COLLECT;
        bus.we       = state == WRITE;
        bus.busy     = state != IDLE;
        bus.cpu_hold = state != IDLE;
        bus.done     = state == FINISH;
    end
    // waddr/wdata are captured with the last byte so they are valid throughout WRITE and hold afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                addr      <= bus.base_addr;
                remaining <= bus.word_count;
                byte_idx  <= '0;
            end
            if (accept) begin
                shreg    <= shreg_nx;
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                if (last_byte) begin
                    waddr_q <= addr;
                    wdata_q <= shreg_nx;
                end
            end
            if (state == WRITE) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
endmodule
